stream_fall_through_buffer: RTL and testbench

Parametrised multi-entry stream buffer with valid/ready handshakes on both ports, in the same family as the single-entry fall-through register. Generalises depth (DEPTH entries, any value ≥ 1, not only powers of two) and adds a selectable fall-through or registered mode. Also adds occupancy, full and empty status outputs. Used between stream producers and consumers that need elasticity without a separate FIFO instance.

---
 rtl/stream_fall_through_buffer.sv | 118 +++++++++++
 tb/tb_stream_fall_through_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fall_through_buffer.sv
// Elastic valid/ready stream buffer, DEPTH entries, optional fall-through.
// Ports: clk_i/rst_ni/clr_i, in (valid_i/ready_o/data_i), out (valid_o/ready_i/data_o), status usage_o/full_o/empty_o.
module stream_fall_through_buffer #(
  parameter int T_w          = 1,
  parameter int DEPTH        = 2,
  parameter bit FALL_THROUGH = 1'b1,
  parameter int CNT_w        = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [T_w-1:0]   data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [T_w-1:0]   data_o,
  output logic [CNT_w-1:0] usage_o,
  output logic             full_o,
  output logic             empty_o
);

  if (DEPTH < 1) begin : g_depth_check
    $error("stream_fall_through_buffer: DEPTH must be >= 1");
  end

  localparam int PTR_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_w-1:0] LAST = PTR_w'(DEPTH - 1);

  logic [T_w-1:0]   mem [DEPTH];
  logic [PTR_w-1:0] wr_ptr;
  logic [PTR_w-1:0] rd_ptr;
  logic [CNT_w-1:0] usage;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             wr_en;
  logic             rd_en;

  // Pointers wrap explicitly so non power-of-two depths work.
  function automatic logic [PTR_w-1:0] nxt(
    input logic [PTR_w-1:0] p
  );
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (usage == '0);
  assign full    = (usage == CNT_w'(DEPTH));
  assign usage_o = usage;
  assign empty_o = empty;
  assign full_o  = full;

  // No ready_i term here: upstream never sees a combinational path
  // through the buffer, so a pop while full cannot admit a push.
  assign ready_o = ~full & ~clr_i;

  always_comb begin
    valid_o = ~empty & ~clr_i;
    data_o  = mem[rd_ptr];
    if (FALL_THROUGH && empty) begin
      valid_o = valid_i & ~clr_i;
      data_o  = data_i;
    end
  end

  assign push   = valid_i & ready_o;
  assign pop    = valid_o & ready_i;
  // Beat enters and leaves in the same cycle without touching storage.
  assign bypass = FALL_THROUGH & empty & push & ready_i;
  assign wr_en  = push & ~bypass;
  assign rd_en  = pop & ~bypass;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usage  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      usage  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= nxt(wr_ptr);
      end
      if (rd_en) begin
        rd_ptr <= nxt(rd_ptr);
      end
      unique case ({wr_en, rd_en})
        2'b10:   usage <= usage + 1'b1;
        2'b01:   usage <= usage - 1'b1;
        default: usage <= usage;
      endcase
    end
  end

  a_no_push_full : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    full |-> !push
  );

  a_no_pop_empty : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (pop && empty) |-> (FALL_THROUGH && push)
  );

  a_data_stable : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (valid_o && !ready_i) |=> $stable(data_o)
  );

endmodule

// File: tb/tb_stream_fall_through_buffer.sv
// Bench for stream_fall_through_buffer: lane 0 fall-through, lane 1 registered.
// Directed scenarios then random traffic; queue model plus output scoreboard.
module tb_stream_fall_through_buffer;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr   = 1'b0;
  logic [1:0]      valid_i;
  logic [1:0]      ready_i;
  logic [1:0][7:0] data_i;
  logic [1:0]      valid_o;
  logic [1:0]      ready_o;
  logic [1:0][7:0] data_o;
  logic [1:0][1:0] usage_o;
  logic [1:0]      full_o;
  logic [1:0]      empty_o;

  always #5 clk = ~clk;

  stream_fall_through_buffer #(
    .T_w(8), .DEPTH(3), .FALL_THROUGH(1'b1)
  ) u_ft (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .valid_i(valid_i[0]), .ready_o(ready_o[0]),
    .data_i(data_i[0]), .valid_o(valid_o[0]),
    .ready_i(ready_i[0]), .data_o(data_o[0]),
    .usage_o(usage_o[0]), .full_o(full_o[0]),
    .empty_o(empty_o[0])
  );

  stream_fall_through_buffer #(
    .T_w(8), .DEPTH(3), .FALL_THROUGH(1'b0)
  ) u_reg (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
    .valid_i(valid_i[1]), .ready_o(ready_o[1]),
    .data_i(data_i[1]), .valid_o(valid_o[1]),
    .ready_i(ready_i[1]), .data_o(data_o[1]),
    .usage_o(usage_o[1]), .full_o(full_o[1]),
    .empty_o(empty_o[1])
  );

  // mq: contents the buffer should hold; sb: accepted beats not yet seen.
  logic [7:0] mq [2][$];
  logic [7:0] sb [2][$];
  int errs   = 0;
  int checks = 0;
  bit done    = 1'b0;
  bit drained = 1'b0;

  task automatic chk(input string nm, input int l,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s lane%0d: got %0h expected %0h",
               nm, l, act, exp);
    end
  endtask

  task automatic step(input int l);
    int         n;
    bit         ft, emp, ful, e_rdy, e_vld, byp;
    logic [7:0] e_dat;
    logic [7:0] exp_d;
    ft  = (l == 0);
    n   = mq[l].size();
    emp = (n == 0);
    ful = (n == 3);
    e_rdy = !ful && !clr;
    if (ft && emp) begin
      e_vld = valid_i[l] && !clr;
      e_dat = data_i[l];
    end else begin
      e_vld = !emp && !clr;
      e_dat = emp ? 8'h00 : mq[l][0];
    end
    chk("ready_o", l, ready_o[l], e_rdy);
    chk("valid_o", l, valid_o[l], e_vld);
    chk("usage_o", l, usage_o[l], n);
    chk("full_o",  l, full_o[l],  ful);
    chk("empty_o", l, empty_o[l], emp);
    if (e_vld) chk("data_o", l, data_o[l], e_dat);
    if (valid_i[l] && ready_o[l]) sb[l].push_back(data_i[l]);
    if (valid_o[l] && ready_i[l]) begin
      checks++;
      if (sb[l].size() == 0) begin
        errs++;
        $display("FAIL sb_pop lane%0d: got beat %0h expected none",
                 l, data_o[l]);
      end else begin
        exp_d = sb[l].pop_front();
        if (data_o[l] !== exp_d) begin
          errs++;
          $display("FAIL sb_order lane%0d: got %0h expected %0h",
                   l, data_o[l], exp_d);
        end
      end
    end
    if (clr) begin
      mq[l].delete();
      sb[l].delete();
    end else begin
      byp = ft && emp && valid_i[l] && ready_i[l];
      if (!byp) begin
        if (e_vld && ready_i[l]) mq[l].delete(0);
        if (valid_i[l] && e_rdy) mq[l].push_back(data_i[l]);
      end
    end
  endtask

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      for (int l = 0; l < 2; l++) begin
        mq[l].delete();
        sb[l].delete();
        chk("rst_valid", l, valid_o[l], 0);
        chk("rst_ready", l, ready_o[l], 1);
        chk("rst_usage", l, usage_o[l], 0);
        chk("rst_empty", l, empty_o[l], 1);
        chk("rst_full",  l, full_o[l],  0);
        chk("rst_data",  l, data_o[l],  0);
      end
    end else begin
      for (int l = 0; l < 2; l++) step(l);
      if (done && !drained) begin
        drained = 1'b1;
        for (int l = 0; l < 2; l++)
          chk("drain", l, sb[l].size(), 0);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d);
    data_i  = {d, d};
    valid_i = 2'b11;
    cyc();
  endtask

  logic [1:0] acc;

  initial begin
    valid_i = '0;
    ready_i = '0;
    data_i  = '0;
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // same-cycle fall-through vs one-cycle latency
    ready_i = 2'b11;
    put(8'h11);
    valid_i = '0;
    repeat (2) cyc();

    // fill to full, then drain in order
    ready_i = 2'b00;
    put(8'hA1);
    put(8'hA2);
    put(8'hA3);
    valid_i = '0;
    cyc();
    ready_i = 2'b11;
    repeat (5) cyc();

    // registered lane: beat visible the cycle after push
    valid_i   = 2'b10;
    data_i[1] = 8'h55;
    cyc();
    valid_i = '0;
    repeat (2) cyc();

    // preload one entry then stream 10 beats with pointer wrap
    ready_i = 2'b00;
    put(8'hFF);
    ready_i = 2'b11;
    for (int i = 0; i < 10; i++) put(8'(i));
    valid_i = '0;
    repeat (3) cyc();

    // clear with a beat offered at the same time
    ready_i = 2'b00;
    put(8'hC1);
    put(8'hC2);
    clr = 1'b1;
    put(8'h77);
    clr     = 1'b0;
    valid_i = '0;
    cyc();
    ready_i = 2'b11;
    repeat (3) cyc();

    // asynchronous reset in mid-cycle with contents held
    ready_i = 2'b00;
    put(8'hD1);
    put(8'hD2);
    valid_i = '0;
    data_i  = '0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    cyc();
    ready_i = 2'b11;
    put(8'h42);
    valid_i = '0;
    repeat (2) cyc();

    // random traffic with compliant upstream holding data
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      acc = valid_i & ready_o;
      @(posedge clk);
      #1;
      for (int l = 0; l < 2; l++) begin
        if (acc[l] || !valid_i[l]) begin
          valid_i[l] = ($urandom % 4) != 0;
          data_i[l]  = 8'($urandom);
        end
        if (((i / 500) % 2) == 0)
          ready_i[l] = ($urandom % 3) != 0;
        else
          ready_i[l] = ($urandom % 3) == 0;
      end
      clr = ($urandom % 50) == 0;
    end

    clr     = 1'b0;
    valid_i = '0;
    ready_i = 2'b11;
    repeat (10) cyc();
    done = 1'b1;
    @(negedge clk);
    #2;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
